// File: rtl/psk_packetizer.sv
// PSK transmit framer: buffers one AXI-stream byte packet, then emits
// preamble, Barker sync, length header, payload and guard at the symbol strobe rate.
module psk_packetizer #(
  parameter int PREAMBLE_LEN = 32,
  parameter int GUARD_LEN    = 8,
  parameter int MAX_BYTES    = 255
) (
  input  logic       clk_32M768,
  input  logic       rst_32M768,
  input  logic       clk_enable,
  input  logic       is_bpsk,
  input  logic [7:0] data_tdata,
  input  logic       data_tvalid,
  output logic       data_tready,
  input  logic       data_tlast,
  output logic       BPSK,
  output logic [1:0] QPSK,
  output logic       sym_valid,
  output logic       is_bpsk_out,
  output logic       busy,
  output logic       frame_done,
  output logic       trunc
);

  typedef enum logic [2:0] {FILL, ARM, PREAMBLE, SYNC, HEADER, PAYLOAD, GUARD} state_t;

  // chip 0 sits in the MSB
  localparam logic [12:0] BARKER = 13'b1111100110101;

  state_t     state, nstate;
  logic [7:0] idx, nidx, pidx, npidx, count;
  logic [7:0] mem [MAX_BYTES];
  logic [1:0] nsym;
  logic       nvalid, accept, at_max, close_pkt;
  logic [2:0] last_sub;

  // Symbol s of byte b: BPSK takes one bit MSB first, QPSK takes {b7,b6} first.
  function automatic logic [1:0] byte_sym(input logic [7:0] b, input logic [7:0] s,
                                          input logic bpsk);
    logic [2:0] hi;
    if (bpsk) begin
      hi = 3'd7 - s[2:0];
      return {b[hi], b[hi]};
    end
    hi = 3'd7 - {s[1:0], 1'b0};
    return {b[hi], b[hi - 3'd1]};
  endfunction

  assign data_tready = (state == FILL) && !rst_32M768;
  assign busy        = (state != FILL);
  assign accept      = data_tvalid && data_tready;
  assign at_max      = (count == 8'(MAX_BYTES - 1));
  assign close_pkt   = accept && (data_tlast || at_max);
  assign last_sub    = is_bpsk_out ? 3'd7 : 3'd3;

  // Next symbol to present on the coming strobe; outputs always carry the
  // symbol of the state/index they were loaded with.
  always_comb begin
    nstate = state;
    nidx   = idx;
    npidx  = pidx;
    nsym   = 2'b00;
    nvalid = 1'b0;
    case (state)
      ARM: begin
        nstate = PREAMBLE;
        nidx   = 8'd0;
        nsym   = 2'b11;
        nvalid = 1'b1;
      end
      PREAMBLE: begin
        nvalid = 1'b1;
        if (idx == 8'(PREAMBLE_LEN - 1)) begin
          nstate = SYNC;
          nidx   = 8'd0;
          nsym   = {2{BARKER[12]}};
        end else begin
          nidx = idx + 8'd1;
          nsym = {2{~nidx[0]}};
        end
      end
      SYNC: begin
        nvalid = 1'b1;
        if (idx == 8'd12) begin
          nstate = HEADER;
          nidx   = 8'd0;
          nsym   = byte_sym(count, 8'd0, is_bpsk_out);
        end else begin
          nidx = idx + 8'd1;
          nsym = {2{BARKER[4'd12 - nidx[3:0]]}};
        end
      end
      HEADER: begin
        nvalid = 1'b1;
        if (idx == {5'd0, last_sub}) begin
          nstate = PAYLOAD;
          nidx   = 8'd0;
          npidx  = 8'd0;
          nsym   = byte_sym(mem[0], 8'd0, is_bpsk_out);
        end else begin
          nidx = idx + 8'd1;
          nsym = byte_sym(count, nidx, is_bpsk_out);
        end
      end
      PAYLOAD: begin
        if (idx == {5'd0, last_sub}) begin
          nidx = 8'd0;
          if (pidx == count - 8'd1) begin
            nstate = GUARD;
          end else begin
            nvalid = 1'b1;
            npidx  = pidx + 8'd1;
            nsym   = byte_sym(mem[npidx], 8'd0, is_bpsk_out);
          end
        end else begin
          nvalid = 1'b1;
          nidx   = idx + 8'd1;
          nsym   = byte_sym(mem[pidx], nidx, is_bpsk_out);
        end
      end
      GUARD: begin
        if (idx == 8'(GUARD_LEN - 1)) nstate = FILL;
        else                          nidx   = idx + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      state       <= FILL;
      idx         <= 8'd0;
      pidx        <= 8'd0;
      count       <= 8'd0;
      BPSK        <= 1'b0;
      QPSK        <= 2'b00;
      sym_valid   <= 1'b0;
      is_bpsk_out <= 1'b1;
      frame_done  <= 1'b0;
      trunc       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      trunc      <= 1'b0;
      if (state == FILL) begin
        if (accept) count <= count + 8'd1;
        if (close_pkt) begin
          state       <= ARM;
          is_bpsk_out <= is_bpsk;
          trunc       <= !data_tlast;
        end
      end else if (clk_enable) begin
        state      <= nstate;
        idx        <= nidx;
        pidx       <= npidx;
        BPSK       <= nsym[1];
        QPSK       <= nsym;
        sym_valid  <= nvalid;
        frame_done <= (nstate == GUARD) && (nidx == 8'(GUARD_LEN - 1));
        if (nstate == FILL) count <= 8'd0;
      end
    end
  end

  // Buffer is never cleared; count alone defines the valid contents.
  always_ff @(posedge clk_32M768) begin
    if (accept) mem[count] <= data_tdata;
  end

endmodule

// File: tb/tb_psk_packetizer.sv
// Bench for psk_packetizer: directed vector table, hand sequences and random
// traffic checked symbol-by-symbol against a frame-level reference model.
module tb_psk_packetizer;
  localparam int PL = 32;
  localparam int GL = 8;
  localparam int MB = 255;

  logic       clk_32M768 = 1'b0;
  logic       rst_32M768, clk_enable, is_bpsk;
  logic [7:0] data_tdata;
  logic       data_tvalid, data_tready, data_tlast;
  logic       BPSK, sym_valid, is_bpsk_out, busy, frame_done, trunc;
  logic [1:0] QPSK;

  psk_packetizer #(.PREAMBLE_LEN(PL), .GUARD_LEN(GL), .MAX_BYTES(MB)) dut (
    .clk_32M768(clk_32M768), .rst_32M768(rst_32M768), .clk_enable(clk_enable),
    .is_bpsk(is_bpsk), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
    .data_tready(data_tready), .data_tlast(data_tlast), .BPSK(BPSK), .QPSK(QPSK),
    .sym_valid(sym_valid), .is_bpsk_out(is_bpsk_out), .busy(busy),
    .frame_done(frame_done), .trunc(trunc));

  always #5 clk_32M768 = ~clk_32M768;

  int tests = 0, fails = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic valid; logic b; logic [1:0] q; logic done; logic chk_b; logic chk_q; logic mode;
  } sym_t;

  sym_t       exp_syms[$];
  logic [7:0] pkt[$];
  int         fvq[$];
  int         frames_done = 0, cur_valid = 0, cur_guard = 0, last_valid = 0, last_guard = 0;
  int         trunc_cnt = 0, sym_idx = 0;
  logic       prev_en = 0, prev_busy = 0, exp_trunc = 0;
  int         barker[13] = '{1,1,1,1,1,0,0,1,1,0,1,0,1};

  function automatic void push_sym(logic v, logic bb, logic [1:0] qq, logic cb, logic cq,
                                   logic m, logic d);
    sym_t s;
    s.valid = v; s.b = bb; s.q = qq; s.chk_b = cb; s.chk_q = cq; s.mode = m; s.done = d;
    exp_syms.push_back(s);
  endfunction

  function automatic void push_byte(logic [7:0] v, logic m);
    if (m) for (int i = 7; i >= 0; i--) push_sym(1'b1, v[i], 2'b00, 1'b1, 1'b0, m, 1'b0);
    else   for (int i = 3; i >= 0; i--) push_sym(1'b1, 1'b0, {v[2*i+1], v[2*i]}, 1'b0, 1'b1, m, 1'b0);
  endfunction

  function automatic void push_frame(logic m);
    logic bit_v;
    for (int k = 0; k < PL; k++) begin
      bit_v = (k % 2 == 0);
      push_sym(1'b1, bit_v, {bit_v, bit_v}, 1'b1, 1'b1, m, 1'b0);
    end
    for (int k = 0; k < 13; k++) begin
      bit_v = (barker[k] == 1);
      push_sym(1'b1, bit_v, {bit_v, bit_v}, 1'b1, 1'b1, m, 1'b0);
    end
    push_byte(8'(pkt.size()), m);
    foreach (pkt[i]) push_byte(pkt[i], m);
    for (int g = 0; g < GL; g++) push_sym(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, m, g == GL - 1);
  endfunction

  // Monitor: mid-cycle sampling; a symbol is recorded after every strobe edge
  // taken while the frame was in flight and still is.
  always @(negedge clk_32M768) begin
    sym_t e;
    logic ok;
    if (rst_32M768) begin
      exp_syms.delete(); pkt.delete();
      prev_en = 0; prev_busy = 0; exp_trunc = 0; cur_valid = 0; cur_guard = 0; sym_idx = 0;
    end else begin
      tests++;
      if (data_tready !== !busy) begin
        fails++; $display("FAIL tready_vs_busy t=%0t tready=%0b busy=%0b", $time, data_tready, busy);
      end
      if (!busy) begin
        tests++;
        if ({sym_valid, BPSK, QPSK} !== 4'b0) begin
          fails++; $display("FAIL idle_outputs t=%0t got v=%0b B=%0b Q=%0b want 0", $time, sym_valid, BPSK, QPSK);
        end
      end
      tests++;
      if (trunc !== exp_trunc) begin
        fails++; $display("FAIL trunc t=%0t got %0b want %0b", $time, trunc, exp_trunc);
      end
      if (trunc === 1'b1) trunc_cnt++;
      if (prev_en && prev_busy && busy) begin
        tests++;
        if (exp_syms.size() == 0) begin
          fails++; $display("FAIL extra_symbol t=%0t", $time);
        end else begin
          e = exp_syms.pop_front();
          ok = (sym_valid === e.valid) && (frame_done === e.done) && (is_bpsk_out === e.mode) &&
               (!e.chk_b || BPSK === e.b) && (!e.chk_q || QPSK === e.q);
          if (!ok) begin
            fails++;
            $display("FAIL symbol %0d t=%0t got v=%0b d=%0b m=%0b B=%0b Q=%b want v=%0b d=%0b m=%0b B=%0b Q=%b",
                     sym_idx, $time, sym_valid, frame_done, is_bpsk_out, BPSK, QPSK,
                     e.valid, e.done, e.mode, e.b, e.q);
          end
        end
        sym_idx++;
        if (sym_valid) cur_valid++; else cur_guard++;
        if (frame_done) begin
          fvq.push_back(cur_valid);
          last_valid = cur_valid; last_guard = cur_guard;
          frames_done++; cur_valid = 0; cur_guard = 0; sym_idx = 0;
        end
      end else begin
        tests++;
        if (frame_done !== 1'b0) begin
          fails++; $display("FAIL stray_frame_done t=%0t got %0b want 0", $time, frame_done);
        end
      end
      exp_trunc = 0;
      if (data_tvalid && data_tready) begin
        pkt.push_back(data_tdata);
        if (data_tlast) begin
          push_frame(is_bpsk); pkt.delete();
        end else if (pkt.size() == MB) begin
          push_frame(is_bpsk); pkt.delete(); exp_trunc = 1;
        end
      end
      prev_en = clk_enable; prev_busy = busy;
    end
  end

  // ---------------- strobe / mode generator ----------------
  int   gap_mode = 0, en_period = 4, gap_cnt = 0;
  logic mode_req = 1'b1, tog_en = 1'b0;

  function automatic int next_gap();
    if (gap_mode == 0) return en_period;
    case ($urandom_range(0, 3))
      0: return 1;
      1: return 2;
      2: return 32;
      default: return $urandom_range(1, 6);
    endcase
  endfunction

  initial begin
    clk_enable = 1'b0;
    is_bpsk    = 1'b1;
    forever begin
      @(posedge clk_32M768); #2;
      if (gap_cnt <= 0) begin clk_enable = 1'b1; gap_cnt = next_gap() - 1; end
      else begin clk_enable = 1'b0; gap_cnt--; end
      is_bpsk = tog_en ? 1'($urandom_range(0, 1)) : mode_req;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tx[512];

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++; $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic send_bytes(input int start, input int n);
    logic acc;
    int   w;
    for (int i = start; i < start + n; i++) begin
      data_tdata  = tx[i];
      data_tlast  = (i == start + n - 1);
      data_tvalid = 1'b1;
      w = 0;
      do begin
        @(negedge clk_32M768); acc = data_tready;
        @(posedge clk_32M768); #2; w++;
      end while (!acc && w < 20000);
      if (!acc) begin
        tests++; fails++; $display("FAIL send_timeout byte %0d", i);
      end
    end
    data_tvalid = 1'b0;
    data_tlast  = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int w = 0;
    while (frames_done < target && w < 60000) begin
      @(posedge clk_32M768); #2; w++;
    end
    if (frames_done < target) begin
      tests++; fails++; $display("FAIL frame_timeout got %0d want %0d", frames_done, target);
    end
  endtask

  typedef struct {
    logic mode; int n; logic [7:0] b0; logic [7:0] b1; int period; int exp_valid; int exp_guard;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int base, w;
    vecs[0] = '{1'b1, 1, 8'hA5, 8'h00, 4, 61, 8};
    vecs[1] = '{1'b0, 2, 8'h1B, 8'hE4, 3, 57, 8};
    vecs[2] = '{1'b1, 2, 8'h00, 8'hFF, 1, 69, 8};
    vecs[3] = '{1'b0, 1, 8'h80, 8'h00, 2, 53, 8};

    rst_32M768 = 1'b1; data_tdata = 8'h00; data_tvalid = 1'b0; data_tlast = 1'b0;
    #1;
    check("reset_BPSK", BPSK, 0);           check("reset_QPSK", QPSK, 0);
    check("reset_sym_valid", sym_valid, 0); check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0); check("reset_trunc", trunc, 0);
    check("reset_is_bpsk_out", is_bpsk_out, 1); check("reset_tready", data_tready, 0);
    repeat (3) @(posedge clk_32M768);
    #3 rst_32M768 = 1'b0;
    #1 check("tready_after_release", data_tready, 1);
    @(posedge clk_32M768); #2;

    // directed single-packet frames
    foreach (vecs[i]) begin
      mode_req = vecs[i].mode; en_period = vecs[i].period;
      @(posedge clk_32M768); #2;
      tx[0] = vecs[i].b0; tx[1] = vecs[i].b1;
      base = frames_done;
      send_bytes(0, vecs[i].n);
      wait_frames(base + 1);
      check($sformatf("vec%0d_valid_syms", i), last_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_guard_syms", i), last_guard, vecs[i].exp_guard);
    end

    // backpressure: second byte held valid throughout the first frame
    mode_req = 1'b1; en_period = 2;
    @(posedge clk_32M768); #2;
    tx[0] = 8'h3C; tx[1] = 8'hC3;
    base = frames_done;
    send_bytes(0, 1);
    send_bytes(1, 1);
    wait_frames(base + 2);
    check("backpressure_frames", frames_done - base, 2);
    check("backpressure_len2", last_valid, 61);

    // truncation: 300 bytes in QPSK splits into 255 + 45
    mode_req = 1'b0; en_period = 1; trunc_cnt = 0;
    @(posedge clk_32M768); #2;
    for (int i = 0; i < 300; i++) tx[i] = 8'((i * 37 + 11) & 255);
    base = frames_done;
    send_bytes(0, 300);
    wait_frames(base + 2);
    check("trunc_pulses", trunc_cnt, 1);
    if (fvq.size() >= 2) begin
      check("trunc_frame1_valid", fvq[fvq.size()-2], PL + 13 + 4 + 4 * 255);
      check("trunc_frame2_valid", fvq[fvq.size()-1], PL + 13 + 4 + 4 * 45);
    end

    // reset mid-payload, then a clean 1-byte frame
    mode_req = 1'b1; en_period = 2;
    @(posedge clk_32M768); #2;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
    send_bytes(0, 4);
    w = 0;
    while (cur_valid < PL + 13 + 8 + 10 && w < 5000) begin
      @(posedge clk_32M768); #2; w++;
    end
    check("reached_payload", int'(cur_valid >= PL + 13 + 8 + 10), 1);
    #1 rst_32M768 = 1'b1;
    #1;
    check("midrst_BPSK", BPSK, 0);            check("midrst_QPSK", QPSK, 0);
    check("midrst_sym_valid", sym_valid, 0);  check("midrst_busy", busy, 0);
    check("midrst_is_bpsk_out", is_bpsk_out, 1); check("midrst_tready", data_tready, 0);
    @(posedge clk_32M768); @(posedge clk_32M768);
    #3 rst_32M768 = 1'b0;
    @(posedge clk_32M768); #2;
    tx[0] = 8'hA5;
    base = frames_done;
    send_bytes(0, 1);
    wait_frames(base + 1);
    check("post_reset_valid", last_valid, 61);

    // irregular strobes and is_bpsk toggling every cycle
    gap_mode = 1; tog_en = 1'b1;
    base = frames_done;
    for (int p = 0; p < 16; p++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
      send_bytes(0, n);
    end
    wait_frames(base + 16);
    check("random_frames", frames_done - base, 16);

    repeat (4) @(posedge clk_32M768);
    check("model_drained", exp_syms.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
